hex_display_scan: RTL

// - Time-multiplexes a NUM_DIGITS-nibble value onto one shared hex-to-7-segment decoder.
// - Sits directly upstream of the decoder:
//   - hex_out feeds the decoder's 4-bit input.
//   - digit_en_n drives the common-anode digit enables of the display.
// - Values are double-buffered, so a new value is only applied at a frame boundary and a frame never shows mixed old/new digits.
//

---
 rtl/hex_display_pkg.sv | 15 +
 rtl/scan_prescaler.sv | 29 ++
 rtl/hex_display_scan.sv | 114 +++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and helpers for the hex display scanner.
// Latency: none (declarations only).
// Backpressure: not applicable.
package hex_display_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] nibble_t;

    // Index width for a digit counter; a single digit still needs one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divide-by-DIV counter producing a one-cycle tick on the last count.
// Latency: tick is combinational from the count register; it is high while count==DIV-1.
// Backpressure: none; the counter never stalls.
module scan_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (DIV <= 1) ? 1 : $clog2(DIV);

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(DIV - 1));

    // Count 0..DIV-1 and wrap back to zero on the tick cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hex_display_scan.sv
// Scans a double-buffered NUM_DIGITS-nibble value onto one shared 7-segment decoder input.
// Latency: outputs are registered one cycle after the digit index / shadow value; new values appear at the next frame.
// Backpressure: none; load is a fire-and-forget strobe (last load in a frame wins). Optional macro: HEX_SCAN_LEADING_ZERO_BLANK_EN.
module hex_display_scan
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    output logic [3:0]                hex_out,
    output logic [NUM_DIGITS-1:0]     digit_en_n,
    output logic                      frame_start
);

    localparam int IDX_W = idx_w(NUM_DIGITS);
    localparam int VAL_W = DIGIT_W * NUM_DIGITS;

    logic                  tick;
    logic                  wrap;
    logic [IDX_W-1:0]      idx;
    logic [VAL_W-1:0]      pending;
    logic [VAL_W-1:0]      shadow;
    nibble_t               cur_nib;
    logic [NUM_DIGITS-1:0] cur_en_n;

    scan_prescaler #(
        .DIV   (REFRESH_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // A frame boundary is the tick on which the last digit hands back to digit 0.
    assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

    // Digit index: step on every tick, wrap to 0 after the last digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (wrap) begin
            idx <= '0;
        end else if (tick) begin
            idx <= idx + 1'b1;
        end
    end

    // Pending register: captures every load; the last one before a boundary wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (load) begin
            pending <= value;
        end
    end

    // Shadow register: only changes at a frame boundary, taking a coincident load directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (wrap) begin
            shadow <= load ? value : pending;
        end
    end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] top_nz;

    // Highest nonzero nibble of shadow; stays 0 for an all-zero value so digit 0 remains lit.
    always_comb begin
        top_nz = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (shadow[k*DIGIT_W +: DIGIT_W] != '0) begin
                top_nz = IDX_W'(k);
            end
        end
    end
`endif

    // Select the active nibble and its one-hot-low enable; leading-zero slots go dark when enabled.
    always_comb begin
        cur_nib  = '0;
        cur_en_n = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib     = shadow[k*DIGIT_W +: DIGIT_W];
                cur_en_n[k] = 1'b0;
            end
        end
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
        if (idx > top_nz) begin
            cur_en_n = '1;
        end
`endif
    end

    // Output registers: one cycle behind idx/shadow; frame_start marks the cycle after a wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hex_out     <= '0;
            digit_en_n  <= '1;
            frame_start <= 1'b0;
        end else begin
            hex_out     <= cur_nib;
            digit_en_n  <= cur_en_n;
            frame_start <= wrap;
        end
    end

endmodule
